// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//
// Purpose:
//   Shared definitions for the round-robin / fixed-priority bus arbiter.
//   It holds the arbiter state encoding, the priority mode selectors and a
//   helper that sizes index fields from a requester count.
//
// Contents:
//   arb_state_e  - arbiter state encoding (IDLE, BUSY)
//   ARB_FIXED    - RR_MODE value for fixed priority, master 0 highest
//   ARB_RR       - RR_MODE value for round-robin priority
//   calc_idx_w   - width of an index able to address n requesters (min 1)
// ---------------------------------------------------------------------------
package arb_pkg;

  // IDLE: no bus owner, a fresh arbitration happens every cycle.
  // BUSY: a grant is held until the owner acks or the hold limit forces it off.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single requester still needs a 1-bit index field, so the width never
  // drops below one.
  function automatic int calc_idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
//
// Purpose:
//   Purely combinational rotating-priority selector. It scans the request
//   vector starting at position 'base' and wrapping modulo N. The first
//   asserted request wins. With base held at 0 it is a plain fixed-priority
//   encoder with index 0 highest.
//
// Parameters:
//   N      - number of requesters
//   IDX_W  - width of the index / base pointer
//
// Ports:
//   req    in   N      request vector, one bit per requester
//   base   in   IDX_W  highest-priority position for this scan (< N)
//   grant  out  N      one-hot winner, or zero when nothing is requested
//   idx    out  IDX_W  index of the winner, 0 when nothing is requested
//   any    out  1      high when some request was found
// ---------------------------------------------------------------------------
module arb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The scan position is computed one bit wider than the index. base + off
  // can reach 2N-2, and the extra bit lets a single conditional subtract
  // fold it back into range without a real modulo operator.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Walk the N positions in priority order and lock onto the first hit.
  // Once 'any' is set, later positions are ignored, so the grant is one-hot.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, base} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      pos = sum[IDX_W-1:0];
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter
//
// Purpose:
//   Arbitrates N_MASTERS requesters onto one shared bus. A granted master
//   keeps the bus until the slave side acknowledges (bus_ack) or, when
//   MAX_HOLD is non-zero, until it has held the bus for MAX_HOLD cycles.
//   Priority is fixed (master 0 highest) or round-robin, chosen at
//   elaboration through RR_MODE.
//
// Parameters:
//   N_MASTERS  - number of requesters (2..16)
//   RR_MODE    - ARB_FIXED (0) or ARB_RR (1)
//   MAX_HOLD   - max cycles a grant is held without bus_ack, 0 = no limit
//   IDX_W      - grant index width, derived from N_MASTERS
//
// Ports:
//   clk          in   1          system clock, rising edge
//   reset        in   1          synchronous active-high reset
//   bus_req      in   N_MASTERS  request vector
//   bus_ack      in   1          current owner finished its transfer
//   bus_grant    out  N_MASTERS  registered one-hot-or-zero grant
//   grant_valid  out  1          registered, equals |bus_grant
//   grant_idx    out  IDX_W      registered index of the owner, 0 if none
//   timeout      out  1          registered one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 8,
  parameter int IDX_W     = calc_idx_w(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] bus_req,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] bus_grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  // The hold counter only needs to reach MAX_HOLD-1. The timeout fires
  // there and reloads the counter, so it never climbs further. With the
  // timeout disabled it simply parks at its all-ones value.
  localparam int CNT_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_SAT =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : CNT_W'((1 << CNT_W) - 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

  logic [0:0]           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     hold_cnt;

  logic [N_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 timeout_cond;
  logic                 release_ev;
  logic                 load_grant;
  logic [IDX_W-1:0]     next_ptr;

  // The selector is always evaluated against the live request vector. Its
  // result is only captured on cycles where a new grant may be loaded.
  arb_rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus_req),
    .base  (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Release and load decisions.
  // A forced release needs the owner to have spent MAX_HOLD-1 counted cycles
  // already and still not be acking now, so the grant is visible for at most
  // MAX_HOLD cycles. If ack and the limit land together, it counts as a
  // normal ack. In IDLE the arbiter re-picks every cycle, so bus_ack has no
  // effect there.
  always_comb begin
    timeout_cond = 1'b0;
    if (MAX_HOLD > 0) begin
      timeout_cond = (state == ST_BUSY) && !bus_ack && (hold_cnt == HOLD_SAT);
    end
    release_ev = (state == ST_BUSY) && (bus_ack || timeout_cond);
    load_grant = (state == ST_IDLE) || release_ev;
  end

  // The pointer moves just past the master being granted, so that master
  // becomes lowest priority for the next pick. That same rule demotes a
  // master that was forced off by the hold limit.
  always_comb begin
    next_ptr = '0;
    if (pick_idx != LAST_IDX) begin
      next_ptr = pick_idx + IDX_W'(1);
    end
  end

  // Main state machine with the output registers.
  // Every load of a grant, zero or not, restarts the hold count. The pointer
  // only advances on a real grant, and it stays at zero in fixed-priority
  // mode. Outside a load, a BUSY owner is still holding without an ack, so
  // the counter ticks up and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      bus_grant   <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (load_grant) begin
        bus_grant   <= pick_grant;
        grant_valid <= pick_any;
        grant_idx   <= pick_idx;
        hold_cnt    <= '0;
        timeout     <= timeout_cond;
        state       <= pick_any ? ST_BUSY : ST_IDLE;
        if (pick_any && (RR_MODE == ARB_RR)) begin
          rr_ptr <= next_ptr;
        end
      end else if (state == ST_BUSY) begin
        if (hold_cnt != HOLD_SAT) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
      if (RR_MODE != ARB_RR) begin
        rr_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_bus_arbiter
//
// Purpose:
//   Self-checking bench for rr_bus_arbiter. It holds two instances, one in
//   fixed-priority mode and one in round-robin mode (N_MASTERS=4,
//   MAX_HOLD=8), and shares clock and reset between them. Each table row
//   holds the inputs for one clock edge plus the outputs expected after
//   that edge. Driving a row queues its expectation, and the expectation is
//   popped and compared once the edge has passed.
// ---------------------------------------------------------------------------
module tb_rr_bus_arbiter;

  localparam int N = 4;

  typedef struct {
    logic       sel;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] exp_grant;
    logic       exp_to;
    string      name;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] req_f, req_r;
  logic       ack_f, ack_r;
  logic [3:0] grant_f, grant_r;
  logic       valid_f, valid_r;
  logic [1:0] idx_f, idx_r;
  logic       to_f, to_r;

  int checks;
  int failures;

  vec_t vecs[$];
  vec_t exp_q[$];

  rr_bus_arbiter #(.N_MASTERS(N), .RR_MODE(0), .MAX_HOLD(8)) dut_fix (
    .clk         (clk),
    .reset       (reset),
    .bus_req     (req_f),
    .bus_ack     (ack_f),
    .bus_grant   (grant_f),
    .grant_valid (valid_f),
    .grant_idx   (idx_f),
    .timeout     (to_f)
  );

  rr_bus_arbiter #(.N_MASTERS(N), .RR_MODE(1), .MAX_HOLD(8)) dut_rr (
    .clk         (clk),
    .reset       (reset),
    .bus_req     (req_r),
    .bus_ack     (ack_r),
    .bus_grant   (grant_r),
    .grant_valid (valid_r),
    .grant_idx   (idx_r),
    .timeout     (to_r)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic sel, input logic rst, input logic [3:0] req,
                        input logic ack, input logic [3:0] exp_grant,
                        input logic exp_to, input string name);
    vec_t v;
    v.sel = sel; v.rst = rst; v.req = req; v.ack = ack;
    v.exp_grant = exp_grant; v.exp_to = exp_to; v.name = name;
    vecs.push_back(v);
  endtask

  // Drives one row. The instance not under test is kept idle.
  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    req_f = v.sel ? 4'b0000 : v.req;
    ack_f = v.sel ? 1'b0    : v.ack;
    req_r = v.sel ? v.req   : 4'b0000;
    ack_r = v.sel ? v.ack   : 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic cmp(input string name, input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s %s got=%0d want=%0d", name, what, got, want);
    end
  endtask

  // Pops the oldest expectation and compares all four outputs of its instance.
  task automatic checkOutput();
    vec_t e;
    logic [3:0] g;
    logic       vld, to;
    logic [1:0] ix;
    int         want_idx;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard got=empty want=entry");
      return;
    end
    e = exp_q.pop_front();
    g   = e.sel ? grant_r : grant_f;
    vld = e.sel ? valid_r : valid_f;
    ix  = e.sel ? idx_r   : idx_f;
    to  = e.sel ? to_r    : to_f;
    want_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (e.exp_grant[i]) want_idx = i;
    end
    cmp(e.name, "grant", int'(g), int'(e.exp_grant));
    cmp(e.name, "idx", int'(ix), want_idx);
    cmp(e.name, "valid", int'(vld), int'(|e.exp_grant));
    cmp(e.name, "timeout", int'(to), int'(e.exp_to));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    req_f = '0; ack_f = 1'b0; req_r = '0; ack_r = 1'b0;

    // Fixed priority: hold without ack, ack handover, ack to idle, no rotation.
    addVec(0, 1, 4'b0000, 0, 4'b0000, 0, "fix_reset");
    addVec(0, 0, 4'b1010, 0, 4'b0010, 0, "fix_first");
    for (int i = 0; i < 5; i++) addVec(0, 0, 4'b1010, 0, 4'b0010, 0, "fix_hold");
    addVec(0, 0, 4'b1000, 1, 4'b1000, 0, "fix_ack_handover");
    addVec(0, 0, 4'b0000, 1, 4'b0000, 0, "fix_ack_to_idle");
    addVec(0, 0, 4'b0001, 0, 4'b0001, 0, "fix_regrant");
    addVec(0, 0, 4'b0011, 1, 4'b0001, 0, "fix_no_rotate");
    addVec(0, 0, 4'b0000, 1, 4'b0000, 0, "fix_idle");

    // Round-robin: full rotation with wrap back to master 0.
    addVec(1, 1, 4'b0000, 0, 4'b0000, 0, "rr_reset");
    addVec(1, 0, 4'b1111, 0, 4'b0001, 0, "rr_g0");
    addVec(1, 0, 4'b1111, 1, 4'b0010, 0, "rr_g1");
    addVec(1, 0, 4'b1111, 1, 4'b0100, 0, "rr_g2");
    addVec(1, 0, 4'b1111, 1, 4'b1000, 0, "rr_g3");
    addVec(1, 0, 4'b1111, 1, 4'b0001, 0, "rr_wrap");

    // Master 2 held 8 cycles without ack, then forced off to master 0.
    addVec(1, 0, 4'b0100, 1, 4'b0100, 0, "to_grant2");
    for (int i = 0; i < 7; i++) addVec(1, 0, 4'b0101, 0, 4'b0100, 0, "to_hold");
    addVec(1, 0, 4'b0101, 0, 4'b0001, 1, "to_fire");
    addVec(1, 0, 4'b0101, 0, 4'b0001, 0, "to_pulse_end");

    // Ack arrives exactly at the hold limit: no pulse, pointer picks master 2.
    for (int i = 0; i < 6; i++) addVec(1, 0, 4'b0101, 0, 4'b0001, 0, "lim_hold");
    addVec(1, 0, 4'b0101, 1, 4'b0100, 0, "lim_ack_wins");

    // Reset while master 2 owns the bus, then pointer restarts at 0.
    addVec(1, 1, 4'b1111, 0, 4'b0000, 0, "rst_mid_busy");
    addVec(1, 0, 4'b1111, 0, 4'b0001, 0, "rst_ptr_zero");
    addVec(1, 0, 4'b0000, 1, 4'b0000, 0, "rr_ack_idle");
    addVec(1, 0, 4'b0000, 1, 4'b0000, 0, "rr_ack_ignored");
    addVec(1, 0, 4'b1000, 0, 4'b1000, 0, "rr_g3_single");
    addVec(1, 0, 4'b1001, 1, 4'b0001, 0, "rr_ptr_wrapped");

    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      @(posedge clk);
      #1;
      checkOutput();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
